// File: rtl/cmos_io_pkg.sv
// rtl/cmos_io_pkg.sv - shared types and constants for the CMOS NVRAM hps_io bridge
package cmos_io_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DN,
    UP_FETCH,
    UP_LATCH,
    UP_HOLD
  } state_t;

  localparam int         CMOS_DEPTH          = 1024;
  localparam logic [3:0] UPLOAD_PAD          = 4'hF;
  localparam int         DEFAULT_NVRAM_INDEX = 4;

endpackage

// File: rtl/cmos_nvram_io_if.sv
// rtl/cmos_nvram_io_if.sv - hps_io transfer and CMOS port-B signal bundle
interface cmos_nvram_io_if #(
  parameter int CMOS_AW = 10
);

  logic               ioctl_download;
  logic               ioctl_upload;
  logic [15:0]        ioctl_index;
  logic [24:0]        ioctl_addr;
  logic               ioctl_wr;
  logic [7:0]         ioctl_dout;
  logic               ioctl_rd;
  logic [7:0]         ioctl_din;
  logic [CMOS_AW-1:0] cmos_addr;
  logic [3:0]         cmos_wdata;
  logic               cmos_we;
  logic [3:0]         cmos_rdata;
  logic               core_cmos_we;
  logic               pause_req;
  logic               nvram_dirty;

  // Host side: hps_io, the CMOS RAM read port and the game core.
  modport master (
    output ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
           ioctl_wr, ioctl_dout, ioctl_rd, cmos_rdata, core_cmos_we,
    input  ioctl_din, cmos_addr, cmos_wdata, cmos_we, pause_req, nvram_dirty
  );

  modport slave (
    input  ioctl_download, ioctl_upload, ioctl_index, ioctl_addr,
           ioctl_wr, ioctl_dout, ioctl_rd, cmos_rdata, core_cmos_we,
    output ioctl_din, cmos_addr, cmos_wdata, cmos_we, pause_req, nvram_dirty
  );

endinterface

// File: rtl/cmos_nvram_io.sv
// rtl/cmos_nvram_io.sv - moves a 1024 x 4-bit CMOS image between hps_io and the external CMOS RAM
module cmos_nvram_io
  import cmos_io_pkg::*;
#(
  parameter int NVRAM_INDEX = DEFAULT_NVRAM_INDEX,
  parameter int CMOS_AW     = 10
) (
  input  logic               clk_sys,
  input  logic               reset,
  input  logic               ioctl_download,
  input  logic               ioctl_upload,
  input  logic [15:0]        ioctl_index,
  input  logic [24:0]        ioctl_addr,
  input  logic               ioctl_wr,
  input  logic [7:0]         ioctl_dout,
  input  logic               ioctl_rd,
  output logic [7:0]         ioctl_din,
  output logic [CMOS_AW-1:0] cmos_addr,
  output logic [3:0]         cmos_wdata,
  output logic               cmos_we,
  input  logic [3:0]         cmos_rdata,
  input  logic               core_cmos_we,
  output logic               pause_req,
  output logic               nvram_dirty
);

  state_t             state_q, state_d;
  logic [7:0]         din_q, din_d;
  logic [CMOS_AW-1:0] caddr_q, caddr_d;
  logic [3:0]         wdata_q, wdata_d;
  logic               we_q, we_d;
  logic               pause_q, pause_d;
  logic               dirty_q, dirty_d;
  logic [24:0]        fetched_q, fetched_d;

  logic sel;
  logic addr_in_range;
  logic fetched_in_range;
  logic done;
  logic unused_dout_hi;

  assign sel              = (ioctl_index == 16'(NVRAM_INDEX));
  assign addr_in_range    = (ioctl_addr < 25'(CMOS_DEPTH));
  assign fetched_in_range = (fetched_q < 25'(CMOS_DEPTH));
  // The CMOS cells are only 4 bits wide; the high nibble of each byte is padding.
  assign unused_dout_hi   = ^ioctl_dout[7:4];

  always_comb begin
    state_d   = state_q;
    din_d     = din_q;
    caddr_d   = caddr_q;
    wdata_d   = wdata_q;
    we_d      = 1'b0;
    fetched_d = fetched_q;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (sel && ioctl_download) begin
          state_d = DN;
        end else if (sel && ioctl_upload) begin
          state_d = UP_FETCH;
          caddr_d = ioctl_addr[CMOS_AW-1:0];
        end
      end

      DN: begin
        if (ioctl_wr && addr_in_range) begin
          we_d    = 1'b1;
          caddr_d = ioctl_addr[CMOS_AW-1:0];
          wdata_d = ioctl_dout[3:0];
        end
        if (!ioctl_download) begin
          state_d = IDLE;
          done    = 1'b1;
        end
      end

      UP_FETCH: begin
        caddr_d   = ioctl_addr[CMOS_AW-1:0];
        fetched_d = ioctl_addr;
        if (!ioctl_upload) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          state_d = UP_LATCH;
        end
      end

      UP_LATCH: begin
        // cmos_rdata now reflects the address driven during UP_FETCH.
        din_d = fetched_in_range ? {UPLOAD_PAD, cmos_rdata} : 8'hFF;
        if (!ioctl_upload) begin
          state_d = IDLE;
          done    = 1'b1;
        end else begin
          state_d = UP_HOLD;
        end
      end

      UP_HOLD: begin
        if (!ioctl_upload) begin
          state_d = IDLE;
          done    = 1'b1;
        end else if (ioctl_rd || (ioctl_addr != fetched_q)) begin
          state_d = UP_FETCH;
          caddr_d = ioctl_addr[CMOS_AW-1:0];
        end
      end

      default: state_d = IDLE;
    endcase

    // Hold the CPU one extra cycle after a download so the last write lands.
    pause_d = (state_d != IDLE) || (state_q == DN);

    dirty_d = dirty_q;
    if (done) begin
      dirty_d = 1'b0;
    end
    if (core_cmos_we && ((state_q == IDLE) || done)) begin
      dirty_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      din_q     <= 8'hFF;
      caddr_q   <= '0;
      wdata_q   <= 4'h0;
      we_q      <= 1'b0;
      pause_q   <= 1'b0;
      dirty_q   <= 1'b0;
      fetched_q <= '0;
    end else begin
      state_q   <= state_d;
      din_q     <= din_d;
      caddr_q   <= caddr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      pause_q   <= pause_d;
      dirty_q   <= dirty_d;
      fetched_q <= fetched_d;
    end
  end

  assign ioctl_din   = din_q;
  assign cmos_addr   = caddr_q;
  assign cmos_wdata  = wdata_q;
  assign cmos_we     = we_q;
  assign pause_req   = pause_q;
  assign nvram_dirty = dirty_q;

endmodule
